// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, fetches over req/ack, presents one registered COMMAND to decode.
// Optional HLT detection and fetch halt is enabled by defining HALT_DETECT_EN.
module instr_fetch_unit #(
   parameter int          ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [15:0] NOP_WORD = 16'hC0E0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [15:0]       imem_rdata,
   input  logic              stall,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_target,
   output logic [15:0]       COMMAND,
   output logic              cmd_valid,
   output logic [ADDR_W-1:0] cmd_pc,
   output logic              halted
);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_HOLD, S_DISCARD
`ifdef HALT_DETECT_EN
      , S_HALT
`endif
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] disc_addr_q, disc_addr_d;
   logic [15:0]       cmd_q, cmd_d;
   logic              cmd_valid_q, cmd_valid_d;
   logic [ADDR_W-1:0] cmd_pc_q, cmd_pc_d;
   logic [15:0]       skid_q, skid_d;
   logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
   logic              in_halt;
   logic              slot_free;
`ifdef HALT_DETECT_EN
   logic              halted_q, halted_d;

   function automatic logic is_hlt(input logic [15:0] w);
      return (w[15:14] == 2'b11) && (w[7:4] == 4'hF);
   endfunction
`endif

   // DISCARD keeps presenting the abandoned address until memory acks it.
   assign imem_req  = (state_q == S_REQ) || (state_q == S_DISCARD);
   assign imem_addr = (state_q == S_DISCARD) ? disc_addr_q : pc_q;
   assign slot_free = !cmd_valid_q || !stall;
   assign COMMAND   = cmd_q;
   assign cmd_valid = cmd_valid_q;
   assign cmd_pc    = cmd_pc_q;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      disc_addr_d = disc_addr_q;
      cmd_d       = cmd_q;
      cmd_valid_d = cmd_valid_q;
      cmd_pc_d    = cmd_pc_q;
      skid_d      = skid_q;
      skid_pc_d   = skid_pc_q;
      in_halt     = 1'b0;
`ifdef HALT_DETECT_EN
      halted_d    = halted_q;
      in_halt     = (state_q == S_HALT);
`endif

      if (cmd_valid_q && !stall) begin
         cmd_valid_d = 1'b0;
         cmd_d       = NOP_WORD;
      end

      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (imem_ack) begin
               pc_d = pc_q + 1'b1;
               if (slot_free) begin
                  cmd_d       = imem_rdata;
                  cmd_pc_d    = pc_q;
                  cmd_valid_d = 1'b1;
`ifdef HALT_DETECT_EN
                  if (is_hlt(imem_rdata)) begin
                     halted_d = 1'b1;
                     state_d  = S_HALT;
                  end
`endif
               end else begin
                  skid_d    = imem_rdata;
                  skid_pc_d = pc_q;
                  state_d   = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (!stall) begin
               cmd_d       = skid_q;
               cmd_pc_d    = skid_pc_q;
               cmd_valid_d = 1'b1;
               state_d     = S_REQ;
`ifdef HALT_DETECT_EN
               if (is_hlt(skid_q)) begin
                  halted_d = 1'b1;
                  state_d  = S_HALT;
               end
`endif
            end
         end
         S_DISCARD: if (imem_ack) state_d = S_REQ;
         default: state_d = state_q;
      endcase

      // Redirect overrides everything above, including a same-cycle ack.
      if (pc_load && !in_halt) begin
         pc_d        = pc_target;
         cmd_valid_d = 1'b0;
         cmd_d       = NOP_WORD;
         cmd_pc_d    = cmd_pc_q;
`ifdef HALT_DETECT_EN
         halted_d    = halted_q;
`endif
         if (imem_req && !imem_ack) begin
            state_d     = S_DISCARD;
            disc_addr_d = imem_addr;
         end else begin
            state_d = S_REQ;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         disc_addr_q <= RESET_PC;
         cmd_q       <= NOP_WORD;
         cmd_valid_q <= 1'b0;
         cmd_pc_q    <= RESET_PC;
         skid_q      <= 16'h0;
         skid_pc_q   <= RESET_PC;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         disc_addr_q <= disc_addr_d;
         cmd_q       <= cmd_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_pc_q    <= cmd_pc_d;
         skid_q      <= skid_d;
         skid_pc_q   <= skid_pc_d;
      end
   end

`ifdef HALT_DETECT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) halted_q <= 1'b0;
      else       halted_q <= halted_d;
   end
   assign halted = halted_q;
`else
   assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus pushes expected words, a negedge monitor pops them.
module tb_instr_fetch_unit;
   localparam logic [15:0] NOP = 16'hC0E0;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        stall;
   logic        pc_load;
   logic [15:0] pc_target;
   logic [15:0] COMMAND;
   logic        cmd_valid;
   logic [15:0] cmd_pc;
   logic        halted;

   typedef struct packed {
      logic [15:0] w;
      logic [15:0] pc;
   } exp_t;

   exp_t exp_q[$];
   int   n_pass = 0;
   int   n_total = 0;

   instr_fetch_unit dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .stall(stall), .pc_load(pc_load), .pc_target(pc_target),
      .COMMAND(COMMAND), .cmd_valid(cmd_valid), .cmd_pc(cmd_pc), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: every consumed word must be the next expected one.
   always @(negedge clk) begin
      if (!reset) begin
         if (cmd_valid && !stall) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", {COMMAND, cmd_pc}, 32'hxxxx_xxxx);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("word_pc", {COMMAND, cmd_pc}, {e.w, e.pc});
            end
         end else if (!cmd_valid) begin
            chk("bubble_nop", {16'h0, COMMAND}, {16'h0, NOP});
         end
      end
   end

   // One cycle, entered at posedge+1: check req/addr, drive inputs, advance one edge.
   task automatic cyc(input logic req_e, input logic [15:0] addr_e, input logic ack_i,
                      input logic [15:0] data, input logic stall_i, input logic load_i,
                      input logic [15:0] tgt, input logic push);
      chk("imem_req", {31'h0, imem_req}, {31'h0, req_e});
      if (req_e) chk("imem_addr", {16'h0, imem_addr}, {16'h0, addr_e});
      imem_ack   = ack_i;
      imem_rdata = data;
      stall      = stall_i;
      pc_load    = load_i;
      pc_target  = tgt;
      if (push) exp_q.push_back('{w: data, pc: addr_e});
      @(posedge clk); #1;
      if (load_i) exp_q.delete();
      imem_ack = 1'b0;
      pc_load  = 1'b0;
   endtask

   initial begin
      reset = 1'b1; imem_ack = 1'b0; imem_rdata = 16'h0; stall = 1'b0;
      pc_load = 1'b0; pc_target = 16'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cmd", {16'h0, COMMAND}, {16'h0, NOP});
      chk("rst_valid_req_halt", {29'h0, cmd_valid, imem_req, halted}, 32'h0);
      chk("rst_pc_addr", {cmd_pc, imem_addr}, 32'h0);
      reset = 1'b0;

      // Streaming, zero-wait ack
      cyc(0, 16'h0, 0, 16'h0, 0, 0, 16'h0, 0);
      cyc(1, 16'h0000, 1, 16'hA000, 0, 0, 16'h0, 1);
      cyc(1, 16'h0001, 1, 16'hA001, 0, 0, 16'h0, 1);
      cyc(1, 16'h0002, 1, 16'hA002, 0, 0, 16'h0, 1);
      cyc(1, 16'h0003, 1, 16'h8105, 0, 0, 16'h0, 1);

      // Stall with ack -> skid, req drops, then drain
      cyc(1, 16'h0004, 1, 16'h1234, 1, 0, 16'h0, 1);
      chk("stall_hold", {15'h0, cmd_valid, COMMAND}, {15'h0, 1'b1, 16'h8105});
      cyc(0, 16'h0, 0, 16'h0, 1, 0, 16'h0, 0);
      chk("stall_hold2", {16'h0, COMMAND}, {16'h0, 16'h8105});
      cyc(0, 16'h0, 0, 16'h0, 0, 0, 16'h0, 0);
      chk("skid_out", {15'h0, cmd_valid, COMMAND}, {15'h0, 1'b1, 16'h1234});
      cyc(1, 16'h0005, 0, 16'h0, 0, 0, 16'h0, 0);

      // Redirect while a request is outstanding
      cyc(1, 16'h0005, 1, 16'hB005, 0, 0, 16'h0, 1);
      cyc(1, 16'h0006, 1, 16'hB006, 0, 0, 16'h0, 1);
      cyc(1, 16'h0007, 0, 16'h0, 0, 1, 16'h0040, 0);
      chk("flush_bubble", {15'h0, cmd_valid, COMMAND}, {15'h0, 1'b0, NOP});
      cyc(1, 16'h0007, 1, 16'hDEAD, 0, 0, 16'h0, 0);
      cyc(1, 16'h0040, 1, 16'hC040, 0, 0, 16'h0, 1);
      cyc(1, 16'h0041, 1, 16'hC041, 0, 0, 16'h0, 1);

      // Redirect coincident with ack and stall
      cyc(1, 16'h0042, 1, 16'hBEEF, 1, 1, 16'h0080, 0);
      chk("flush_stall", {15'h0, cmd_valid, COMMAND}, {15'h0, 1'b0, NOP});
      cyc(1, 16'h0080, 1, 16'hD080, 0, 0, 16'h0, 1);

      // PC wrap at all-ones
      cyc(1, 16'h0081, 0, 16'h0, 0, 1, 16'hFFFF, 0);
      cyc(1, 16'h0081, 1, 16'h5555, 0, 0, 16'h0, 0);
      cyc(1, 16'hFFFF, 1, 16'hE0FF, 0, 0, 16'h0, 1);
      cyc(1, 16'h0000, 1, 16'hE000, 0, 0, 16'h0, 1);

`ifdef HALT_DETECT_EN
      cyc(1, 16'h0001, 1, 16'hC0F0, 0, 0, 16'h0, 1);
      chk("halted_set", {31'h0, halted}, 32'h1);
      cyc(0, 16'h0, 0, 16'h0, 0, 0, 16'h0, 0);
      cyc(0, 16'h0, 0, 16'h0, 0, 1, 16'h0010, 0);
      cyc(0, 16'h0, 0, 16'h0, 0, 0, 16'h0, 0);
      chk("halted_hold", {31'h0, halted}, 32'h1);
      reset = 1'b1;
      #1;
      chk("halt_reset", {30'h0, halted, cmd_valid}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      cyc(0, 16'h0, 0, 16'h0, 0, 0, 16'h0, 0);
      cyc(1, 16'h0000, 1, 16'h1111, 0, 0, 16'h0, 1);
      cyc(1, 16'h0001, 0, 16'h0, 0, 0, 16'h0, 0);
`else
      cyc(1, 16'h0001, 1, 16'hC0F0, 0, 0, 16'h0, 1);
      cyc(1, 16'h0002, 0, 16'h0, 0, 0, 16'h0, 0);
      chk("no_halt", {31'h0, halted}, 32'h0);
`endif

      cyc(1, imem_addr, 0, 16'h0, 0, 0, 16'h0, 0);
      chk("all_delivered", exp_q.size(), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
